// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the decode / register-file front end:
//   - state_e      : decode FSM states (IDLE, CHECK, HOLD)
//   - *_HI / *_LO  : bit positions of the instruction fields
//   - REG_IDX_W    : width of a register index taken from the instruction
//   - idx_in_range : true when a register index addresses an implemented register
package decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int IR_W  = 16;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RA_HI = 11;
  localparam int RA_LO = 9;
  localparam int RB_HI = 8;
  localparam int RB_LO = 6;
  localparam int FN_HI = 3;
  localparam int FN_LO = 0;

  localparam int REG_IDX_W = 3;

  // Instruction fields are 3 bits wide, so a build with fewer than eight
  // registers can still see indices that name no register at all.
  function automatic logic idx_in_range(input logic [REG_IDX_W-1:0] idx, input int cnt);
    return int'(idx) < cnt;
  endfunction

endpackage

// File: rtl/decode_regfile_sb_regfile.sv
// regfile_2r1w
// Register array with two asynchronous read ports and one synchronous write port.
// Ports:
//   clk, reset             : clock, synchronous active-high clear of every register
//   rd1_addr_i, rd2_addr_i : read indices
//   rd1_data_o, rd2_data_o : read data; a write to the same index in the same cycle
//                            is forwarded, an unimplemented index reads as zero
//   we_i, waddr_i, wdata_i : write strobe, index and data (unimplemented index ignored)
//   m_o                    : raw array content of register MAIN_REG (no forwarding)
module regfile_2r1w
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_CNT  = 8,
  parameter int MAIN_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] rd1_addr_i,
  output logic [DATA_W-1:0]    rd1_data_o,
  input  logic [REG_IDX_W-1:0] rd2_addr_i,
  output logic [DATA_W-1:0]    rd2_data_o,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    m_o
);

  // The array always spans every encodable index; slots past REG_CNT are
  // tied to zero so any out-of-range lookup is harmless.
  localparam int SLOTS = 1 << REG_IDX_W;

  logic [DATA_W-1:0] mem_q [SLOTS];

  // Reset takes priority over a write in the same cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (reset || i >= REG_CNT) begin
        mem_q[i] <= '0;
      end else if (we_i && waddr_i == REG_IDX_W'(i)) begin
        mem_q[i] <= wdata_i;
      end
    end
  end

  // Forwarding lets a consumer capture a value in the same cycle it is written back.
  assign rd1_data_o = !idx_in_range(rd1_addr_i, REG_CNT) ? '0 :
                      (we_i && waddr_i == rd1_addr_i)    ? wdata_i :
                                                           mem_q[rd1_addr_i];
  assign rd2_data_o = !idx_in_range(rd2_addr_i, REG_CNT) ? '0 :
                      (we_i && waddr_i == rd2_addr_i)    ? wdata_i :
                                                           mem_q[rd2_addr_i];

  assign m_o = mem_q[MAIN_REG];

endmodule

// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb
// Decode front end: latches an instruction, selects source/destination
// registers, stalls on RAW/WAW hazards using a per-register busy scoreboard,
// and presents registered operands to execute on a valid/ready handshake.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   ir_valid, ir_ready, ir_in       : instruction handshake from fetch (ready only in IDLE)
//   sel_r1, sel_r2                  : operand selects (r1: MAIN_REG/ra, r2: rb/ra)
//   dest_en, dest_sel               : write-back enable and destination select (MAIN_REG/ra)
//   out_valid, out_ready            : operand handshake to execute
//   out_ir, out_r1, out_r2          : latched instruction and operand data
//   out_dest, out_dest_en           : destination index and write-back enable
//   wb_en, wb_addr, wb_data         : write-back port, accepted in every state
//   m                               : current array content of register MAIN_REG
module decode_regfile_sb
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_CNT  = 8,
  parameter int MAIN_REG = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ir_valid,
  output logic                 ir_ready,
  input  logic [IR_W-1:0]      ir_in,
  input  logic                 sel_r1,
  input  logic                 sel_r2,
  input  logic                 dest_en,
  input  logic                 dest_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IR_W-1:0]      out_ir,
  output logic [DATA_W-1:0]    out_r1,
  output logic [DATA_W-1:0]    out_r2,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 out_dest_en,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output logic [DATA_W-1:0]    m
);

  localparam int SLOTS = 1 << REG_IDX_W;
  localparam logic [REG_IDX_W-1:0] MAIN_IDX = REG_IDX_W'(MAIN_REG);

  state_e                state_q, state_d;
  logic [IR_W-1:0]       ir_q;
  logic                  sel_r1_q, sel_r2_q, dest_en_q, dest_sel_q;
  logic [SLOTS-1:0]      busy_q, busy_d;
  logic [IR_W-1:0]       out_ir_q;
  logic [DATA_W-1:0]     out_r1_q, out_r2_q;
  logic [REG_IDX_W-1:0]  out_dest_q;
  logic                  out_dest_en_q;

  logic [REG_IDX_W-1:0]  ra, rb, r1_idx, r2_idx, dest_idx;
  logic [DATA_W-1:0]     r1_data, r2_data;
  logic [SLOTS-1:0]      wb_hit, busy_eff;
  logic                  hazard, capture;

  assign ra       = ir_q[RA_HI:RA_LO];
  assign rb       = ir_q[RB_HI:RB_LO];
  assign r1_idx   = sel_r1_q   ? ra : MAIN_IDX;
  assign r2_idx   = sel_r2_q   ? ra : rb;
  assign dest_idx = dest_sel_q ? ra : MAIN_IDX;

  // A register being written back this cycle is already free: its value is
  // available through the read forwarding path.
  always_comb begin
    wb_hit = '0;
    if (wb_en && idx_in_range(wb_addr, REG_CNT)) begin
      wb_hit[wb_addr] = 1'b1;
    end
  end

  assign busy_eff = busy_q & ~wb_hit;
  assign hazard   = busy_eff[r1_idx] | busy_eff[r2_idx] | (dest_en_q & busy_eff[dest_idx]);
  assign capture  = (state_q == CHECK) && !hazard;

  // Write-back clears first and capture sets afterwards, so a new writer
  // claiming the register being retired in the same cycle keeps it busy.
  always_comb begin
    busy_d = busy_q & ~wb_hit;
    if (capture && dest_en_q && idx_in_range(dest_idx, REG_CNT)) begin
      busy_d[dest_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ir_valid)  state_d = CHECK;
      CHECK:   if (!hazard)   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= '0;
      ir_q          <= '0;
      sel_r1_q      <= 1'b0;
      sel_r2_q      <= 1'b0;
      dest_en_q     <= 1'b0;
      dest_sel_q    <= 1'b0;
      out_ir_q      <= '0;
      out_r1_q      <= '0;
      out_r2_q      <= '0;
      out_dest_q    <= '0;
      out_dest_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (state_q == IDLE && ir_valid) begin
        ir_q       <= ir_in;
        sel_r1_q   <= sel_r1;
        sel_r2_q   <= sel_r2;
        dest_en_q  <= dest_en;
        dest_sel_q <= dest_sel;
      end
      if (capture) begin
        out_ir_q      <= ir_q;
        out_r1_q      <= r1_data;
        out_r2_q      <= r2_data;
        out_dest_q    <= dest_idx;
        out_dest_en_q <= dest_en_q;
      end
    end
  end

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .MAIN_REG(MAIN_REG)
  ) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd1_addr_i(r1_idx),
    .rd1_data_o(r1_data),
    .rd2_addr_i(r2_idx),
    .rd2_data_o(r2_data),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .m_o       (m)
  );

  assign ir_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == HOLD);
  assign out_ir      = out_ir_q;
  assign out_r1      = out_r1_q;
  assign out_r2      = out_r2_q;
  assign out_dest    = out_dest_q;
  assign out_dest_en = out_dest_en_q;

endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb_decode_regfile_sb
// Self-checking bench: an eight-register instance driven through a scoreboard
// of expected operand bundles, plus a four-register instance for the
// out-of-range index behaviour.
module tb_decode_regfile_sb;
  import decode_pkg::*;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [2:0]  dest;
    logic        dest_en;
  } exp_t;

  exp_t sbQueue[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        ir_valid = 0, ir_ready, sel_r1 = 0, sel_r2 = 0, dest_en = 0, dest_sel = 0;
  logic [15:0] ir_in = '0;
  logic        out_valid, out_ready = 0, out_dest_en, wb_en = 0;
  logic [15:0] out_ir, out_r1, out_r2, wb_data = '0, m;
  logic [2:0]  out_dest, wb_addr = '0;

  logic        ir_valid4 = 0, ir_ready4, sel_r1_4 = 0, sel_r2_4 = 0, dest_en4 = 0, dest_sel4 = 0;
  logic [15:0] ir_in4 = '0;
  logic        out_valid4, out_ready4 = 0, out_dest_en4, wb_en4 = 0;
  logic [15:0] out_ir4, out_r1_4, out_r2_4, wb_data4 = '0, m4;
  logic [2:0]  out_dest4, wb_addr4 = '0;

  decode_regfile_sb #(.DATA_W(16), .REG_CNT(8), .MAIN_REG(0)) dut (
    .clk(clk), .reset(reset), .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_in(ir_in),
    .sel_r1(sel_r1), .sel_r2(sel_r2), .dest_en(dest_en), .dest_sel(dest_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_r1(out_r1),
    .out_r2(out_r2), .out_dest(out_dest), .out_dest_en(out_dest_en),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .m(m)
  );

  decode_regfile_sb #(.DATA_W(16), .REG_CNT(4), .MAIN_REG(0)) dut4 (
    .clk(clk), .reset(reset), .ir_valid(ir_valid4), .ir_ready(ir_ready4), .ir_in(ir_in4),
    .sel_r1(sel_r1_4), .sel_r2(sel_r2_4), .dest_en(dest_en4), .dest_sel(dest_sel4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_ir(out_ir4), .out_r1(out_r1_4),
    .out_r2(out_r2_4), .out_dest(out_dest4), .out_dest_en(out_dest_en4),
    .wb_en(wb_en4), .wb_addr(wb_addr4), .wb_data(wb_data4), .m(m4)
  );

  task automatic expectOut(input logic [15:0] ir, r1, r2, input logic [2:0] dest, input logic de);
    exp_t e;
    e.ir = ir; e.r1 = r1; e.r2 = r2; e.dest = dest; e.dest_en = de;
    sbQueue.push_back(e);
  endtask

  // Offers one instruction; returns on the negedge after the accepting edge.
  task automatic issue(input logic [15:0] ir, input logic s1, s2, de, ds);
    int waited = 0;
    while (ir_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    testsRun++;
    if (ir_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL issue_ready: ir_ready=%b required 1", ir_ready);
    end
    ir_in = ir; sel_r1 = s1; sel_r2 = s2; dest_en = de; dest_sel = ds;
    ir_valid = 1'b1;
    @(negedge clk);
    ir_valid = 1'b0;
  endtask

  // Waits up to maxCyc cycles for out_valid, compares against the scoreboard head, completes the handshake.
  task automatic drain(input string name, input int maxCyc);
    exp_t e;
    int waited = 0;
    while (out_valid !== 1'b1 && waited < maxCyc) begin
      @(negedge clk);
      waited++;
    end
    testsRun++;
    if (sbQueue.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s scoreboard: queue empty, required an entry", name);
      return;
    end
    e = sbQueue.pop_front();
    if (out_valid !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL %s out_valid: got %b required 1 within %0d cycles", name, out_valid, maxCyc);
      return;
    end
    testsRun += 5;
    if (out_ir !== e.ir) begin
      testsFailed++; $display("[TB] FAIL %s out_ir: got %h required %h", name, out_ir, e.ir);
    end
    if (out_r1 !== e.r1) begin
      testsFailed++; $display("[TB] FAIL %s out_r1: got %h required %h", name, out_r1, e.r1);
    end
    if (out_r2 !== e.r2) begin
      testsFailed++; $display("[TB] FAIL %s out_r2: got %h required %h", name, out_r2, e.r2);
    end
    if (out_dest !== e.dest) begin
      testsFailed++; $display("[TB] FAIL %s out_dest: got %0d required %0d", name, out_dest, e.dest);
    end
    if (out_dest_en !== e.dest_en) begin
      testsFailed++; $display("[TB] FAIL %s out_dest_en: got %b required %b", name, out_dest_en, e.dest_en);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0; wb_en = 1'b0;
    testsRun += 5;
    if (ir_ready !== 1'b1 || ir_ready4 !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL reset_ir_ready: got %b/%b required 1/1", ir_ready, ir_ready4);
    end
    if (out_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid);
    end
    if (out_ir !== 16'h0 || out_r1 !== 16'h0 || out_r2 !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL reset_outputs: got %h %h %h required 0 0 0", out_ir, out_r1, out_r2);
    end
    if (out_dest !== 3'd0 || out_dest_en !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL reset_dest: got %0d %b required 0 0", out_dest, out_dest_en);
    end
    if (m !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL reset_m: got %h required 0000", m);
    end
  endtask

  task automatic test_basic();
    expectOut(16'h1280, 16'h0000, 16'h0000, 3'd0, 1'b0);
    issue(16'h1280, 1'b1, 1'b0, 1'b0, 1'b0);
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL basic_latency1: out_valid=%b required 0", out_valid);
    end
    @(negedge clk);
    drain("basic", 0);
    testsRun++;
    if (m !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL basic_m: got %h required 0000", m);
    end
  endtask

  task automatic test_wb_bypass();
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
    @(negedge clk);
    wb_en = 1'b0;
    expectOut(16'h0740, 16'hBEEF, 16'h1234, 3'd0, 1'b0);
    issue(16'h0740, 1'b1, 1'b0, 1'b0, 1'b0);
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h1234;
    @(negedge clk);
    wb_en = 1'b0;
    drain("wb_bypass", 0);
  endtask

  task automatic test_raw();
    expectOut(16'h0800, 16'h0000, 16'h0000, 3'd4, 1'b1);
    issue(16'h0800, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("raw_writer", 2);
    expectOut(16'h0801, 16'h00AA, 16'h00AA, 3'd0, 1'b0);
    issue(16'h0801, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      testsRun++;
      if (out_valid !== 1'b0 || ir_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL raw_stall: out_valid=%b ir_ready=%b required 0 0", out_valid, ir_ready);
      end
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h00AA;
    @(negedge clk);
    wb_en = 1'b0;
    drain("raw_reader", 0);
  endtask

  task automatic test_waw();
    expectOut(16'h06C0, 16'hBEEF, 16'hBEEF, 3'd0, 1'b1);
    issue(16'h06C0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("waw_first", 2);
    expectOut(16'h06C1, 16'hBEEF, 16'hBEEF, 3'd0, 1'b1);
    issue(16'h06C1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      testsRun++;
      if (out_valid !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL waw_stall: out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h5555;
    @(negedge clk);
    wb_en = 1'b0;
    testsRun++;
    if (m !== 16'h5555) begin
      testsFailed++; $display("[TB] FAIL waw_m: got %h required 5555", m);
    end
    drain("waw_second", 0);
    // r0 must still be busy from the second writer.
    expectOut(16'h06C0, 16'h7777, 16'hBEEF, 3'd0, 1'b0);
    issue(16'h06C0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      testsRun++;
      if (out_valid !== 1'b0) begin
        testsFailed++; $display("[TB] FAIL waw_busy_kept: out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h7777;
    @(negedge clk);
    wb_en = 1'b0;
    drain("waw_reader", 0);
  endtask

  task automatic test_hold();
    expectOut(16'h0740, 16'hBEEF, 16'h1234, 3'd0, 1'b0);
    issue(16'h0740, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0F0F;
    ir_valid = 1'b1; ir_in = 16'hFFFF;
    for (int c = 0; c < 5; c++) begin
      testsRun++;
      if (out_valid !== 1'b1 || ir_ready !== 1'b0 || out_ir !== 16'h0740 ||
          out_r1 !== 16'hBEEF || out_r2 !== 16'h1234) begin
        testsFailed++;
        $display("[TB] FAIL hold_stable: valid=%b ready=%b ir=%h r1=%h r2=%h required 1 0 0740 beef 1234",
                 out_valid, ir_ready, out_ir, out_r1, out_r2);
      end
      @(negedge clk);
      wb_en = 1'b0;
    end
    ir_valid = 1'b0;
    drain("hold", 0);
    testsRun++;
    if (out_valid !== 1'b0 || ir_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL hold_release: valid=%b ready=%b required 0 1", out_valid, ir_ready);
    end
  endtask

  task automatic test_reset_in_check();
    expectOut(16'h0C00, 16'h7777, 16'h7777, 3'd6, 1'b1);
    issue(16'h0C00, 1'b0, 1'b0, 1'b1, 1'b1);
    drain("rst_writer", 2);
    issue(16'h0C40, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    testsRun++;
    if (out_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rst_stall: out_valid=%b required 0", out_valid);
    end
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h9999;
    @(negedge clk);
    reset = 1'b0; wb_en = 1'b0;
    testsRun += 3;
    if (ir_ready !== 1'b1 || out_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL rst_state: ready=%b valid=%b required 1 0", ir_ready, out_valid);
    end
    if (out_ir !== 16'h0 || out_r1 !== 16'h0 || out_r2 !== 16'h0 || out_dest !== 3'd0 || out_dest_en !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_outputs: ir=%h r1=%h r2=%h dest=%0d de=%b required all 0",
               out_ir, out_r1, out_r2, out_dest, out_dest_en);
    end
    if (m !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL rst_m: got %h required 0000", m);
    end
    // Busy cleared and the write under reset dropped: no stall, r2 (reg1) reads 0.
    expectOut(16'h0C40, 16'h0000, 16'h0000, 3'd0, 1'b0);
    issue(16'h0C40, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drain("rst_after", 0);
  endtask

  task automatic test_small_regfile();
    wb_en4 = 1'b1; wb_addr4 = 3'd6; wb_data4 = 16'hABCD;
    @(negedge clk);
    wb_addr4 = 3'd0; wb_data4 = 16'h4321;
    @(negedge clk);
    wb_addr4 = 3'd1; wb_data4 = 16'h1111;
    @(negedge clk);
    wb_en4 = 1'b0;
    testsRun++;
    if (m4 !== 16'h4321) begin
      testsFailed++; $display("[TB] FAIL small_m: got %h required 4321", m4);
    end
    for (int k = 0; k < 2; k++) begin
      ir_in4 = 16'h0C40; sel_r1_4 = 1'b1; sel_r2_4 = 1'b0; dest_en4 = 1'b1; dest_sel4 = 1'b1;
      ir_valid4 = 1'b1;
      @(negedge clk);
      ir_valid4 = 1'b0;
      @(negedge clk);
      testsRun += 2;
      if (out_valid4 !== 1'b1) begin
        testsFailed++; $display("[TB] FAIL small_valid%0d: got %b required 1", k, out_valid4);
      end
      if (out_r1_4 !== 16'h0000 || out_r2_4 !== 16'h1111 || out_dest4 !== 3'd6 || out_dest_en4 !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL small_data%0d: r1=%h r2=%h dest=%0d de=%b required 0000 1111 6 1",
                 k, out_r1_4, out_r2_4, out_dest4, out_dest_en4);
      end
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_wb_bypass();
    test_raw();
    test_waw();
    test_hold();
    test_reset_in_check();
    test_small_regfile();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
